// File: rtl/operator_unit_pkg.sv
// Shared types and helpers for the handshaked integer operator unit.
package operator_unit_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_MUL   = 5'd2,
        OP_DIV   = 5'd3,
        OP_MOD   = 5'd4,
        OP_POW   = 5'd5,
        OP_SHL   = 5'd6,
        OP_SHR   = 5'd7,
        OP_ASHR  = 5'd8,
        OP_AND   = 5'd9,
        OP_OR    = 5'd10,
        OP_XOR   = 5'd11,
        OP_XNOR  = 5'd12,
        OP_LT    = 5'd13,
        OP_LE    = 5'd14,
        OP_EQ    = 5'd15,
        OP_NE    = 5'd16,
        OP_RAND  = 5'd17,
        OP_RNAND = 5'd18,
        OP_ROR   = 5'd19,
        OP_RNOR  = 5'd20,
        OP_RXOR  = 5'd21,
        OP_RXNOR = 5'd22
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(op_t op);
        return op inside {OP_DIV, OP_MOD, OP_POW};
    endfunction

    // Iterations spent in BUSY for a given operand width.
    function automatic int unsigned iter_lat(int unsigned width);
        return width;
    endfunction

endpackage

// File: rtl/operator_unit_if.sv
// Request/response handshake bundle for operator_unit.
interface operator_unit_if #(parameter int unsigned WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic             signed_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             out_x;

    modport master (
        output in_valid, op, signed_op, a, b, out_ready,
        input  in_ready, out_valid, result, out_x
    );

    modport slave (
        input  in_valid, op, signed_op, a, b, out_ready,
        output in_ready, out_valid, result, out_x
    );
endinterface

// File: rtl/operator_unit_seq_divider.sv
// Iterative restoring divider on unsigned magnitudes; one quotient bit per cycle.
module seq_divider #(parameter int unsigned WIDTH = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0]    left;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_in, q_in, dsr, rem_nx, q_nx;
    logic [WIDTH:0]   trial;

    // The start cycle already performs the first step, so WIDTH steps end one edge early.
    always_comb begin
        rem_in = start ? '0 : remainder;
        q_in   = start ? dividend : quotient;
        dsr    = start ? divisor : dsr_q;
        trial  = {rem_in, q_in[WIDTH-1]} - {1'b0, dsr};
        if (!trial[WIDTH]) begin
            rem_nx = trial[WIDTH-1:0];
            q_nx   = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = {rem_in[WIDTH-2:0], q_in[WIDTH-1]};
            q_nx   = {q_in[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left      <= '0;
            dsr_q     <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            left      <= CW'(WIDTH - 1);
            dsr_q     <= divisor;
            done      <= 1'b0;
            quotient  <= q_nx;
            remainder <= rem_nx;
        end else if (left != '0) begin
            left      <= left - CW'(1);
            done      <= (left == CW'(1));
            quotient  <= q_nx;
            remainder <= rem_nx;
        end
    end
endmodule

// File: rtl/operator_unit.sv
// Handshaked operator unit: single-cycle ops registered on accept, DIV/MOD/POW iterate in BUSY.
module operator_unit #(parameter int unsigned WIDTH = 32) (
    input logic            clk,
    input logic            rst,
    operator_unit_if.slave bus
);
    import operator_unit_pkg::*;

    localparam int unsigned      ITER_LAT = iter_lat(WIDTH);
    localparam int unsigned      CW       = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] W_LIM    = WIDTH'(WIDTH);

    state_t           state, state_nx;
    op_t              op_in, op_q;
    logic             sgn_q;
    logic [WIDTH-1:0] a_q, b_q, acc, res_q;
    logic             x_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] sc_res, mc_res, acc_sq, pow_step, div_q, div_r;
    logic             sc_x, mc_x, big_sh, div_done, div_start, q_neg, r_neg;

    assign op_in         = op_t'(bus.op);
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign bus.out_x     = x_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = is_multicycle(op_in) ? BUSY : DONE;
            BUSY:    if (cnt == '0) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign big_sh = (bus.b >= W_LIM);

    always_comb begin
        sc_res = '0;
        sc_x   = 1'b0;
        case (op_in)
            OP_ADD:   sc_res = bus.a + bus.b;
            OP_SUB:   sc_res = bus.a - bus.b;
            OP_MUL:   sc_res = bus.a * bus.b;
            OP_SHL:   sc_res = big_sh ? '0 : (bus.a << bus.b);
            OP_SHR:   sc_res = big_sh ? '0 : (bus.a >> bus.b);
            OP_ASHR:
                if (!bus.signed_op) sc_res = big_sh ? '0 : (bus.a >> bus.b);
                else if (big_sh)    sc_res = {WIDTH{bus.a[WIDTH-1]}};
                else                sc_res = $signed(bus.a) >>> bus.b;
            OP_AND:   sc_res = bus.a & bus.b;
            OP_OR:    sc_res = bus.a | bus.b;
            OP_XOR:   sc_res = bus.a ^ bus.b;
            OP_XNOR:  sc_res = ~(bus.a ^ bus.b);
            OP_LT:    sc_res[0] = bus.signed_op ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);
            OP_LE:    sc_res[0] = bus.signed_op ? ($signed(bus.a) <= $signed(bus.b)) : (bus.a <= bus.b);
            OP_EQ:    sc_res[0] = (bus.a == bus.b);
            OP_NE:    sc_res[0] = (bus.a != bus.b);
            OP_RAND:  sc_res[0] = &bus.a;
            OP_RNAND: sc_res[0] = ~&bus.a;
            OP_ROR:   sc_res[0] = |bus.a;
            OP_RNOR:  sc_res[0] = ~|bus.a;
            OP_RXOR:  sc_res[0] = ^bus.a;
            OP_RXNOR: sc_res[0] = ~^bus.a;
            default:  sc_x = 1'b1;
        endcase
    end

    assign div_start = (state == IDLE) && bus.in_valid && (op_in inside {OP_DIV, OP_MOD});

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  ((bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a),
        .divisor   ((bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Exponent bits are consumed MSB-first, indexed directly by the countdown.
    assign acc_sq   = acc * acc;
    assign pow_step = b_q[cnt] ? acc_sq * a_q : acc_sq;
    assign q_neg    = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign r_neg    = sgn_q & a_q[WIDTH-1];

    always_comb begin
        mc_res = '0;
        mc_x   = 1'b0;
        case (op_q)
            OP_DIV:
                if (b_q == '0 || !div_done) mc_x = 1'b1;
                else mc_res = q_neg ? -div_q : div_q;
            OP_MOD:
                if (b_q == '0 || !div_done) mc_x = 1'b1;
                else mc_res = r_neg ? -div_r : div_r;
            OP_POW:
                if (!(sgn_q && b_q[WIDTH-1])) mc_res = pow_step;
                else if (a_q == '0)           mc_x = 1'b1;
                else if (a_q == WIDTH'(1))    mc_res = WIDTH'(1);
                else if (a_q == '1)           mc_res = b_q[0] ? '1 : WIDTH'(1);
            default: mc_x = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= OP_ADD;
            sgn_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
            res_q <= '0;
            x_q   <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (bus.in_valid) begin
                        op_q  <= op_in;
                        sgn_q <= bus.signed_op;
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        acc   <= WIDTH'(1);
                        cnt   <= CW'(ITER_LAT - 1);
                        if (!is_multicycle(op_in)) begin
                            res_q <= sc_res;
                            x_q   <= sc_x;
                        end
                    end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    acc <= pow_step;
                    if (cnt == '0) begin
                        res_q <= mc_res;
                        x_q   <= mc_x;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_operator_unit.sv
// Directed-vector bench for operator_unit at WIDTH=32 and WIDTH=4.
module tb_operator_unit;
    import operator_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    operator_unit_if #(.WIDTH(32)) if32 ();
    operator_unit_if #(.WIDTH(4))  if4 ();

    operator_unit #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(if32));
    operator_unit #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(if4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one request, wait (bounded) for out_valid, capture, then handshake.
    task automatic txn(input bit n, input logic [4:0] op, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r, output logic x, output int lat);
        @(negedge clk);
        if (n) begin
            if4.in_valid = 1'b1; if4.op = op; if4.signed_op = sgn; if4.a = a[3:0]; if4.b = b[3:0];
        end else begin
            if32.in_valid = 1'b1; if32.op = op; if32.signed_op = sgn; if32.a = a; if32.b = b;
        end
        @(posedge clk);
        #1;
        if4.in_valid  = 1'b0;
        if32.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(n ? if4.out_valid : if32.out_valid) && lat < 100);
        r = n ? {28'b0, if4.result} : if32.result;
        x = n ? if4.out_x : if32.out_x;
        if (n) if4.out_ready = 1'b1;
        else   if32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if4.out_ready  = 1'b0;
        if32.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input bit n, input logic [4:0] op, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ex, input int el);
        logic [31:0] r;
        logic        x;
        int          lat;
        txn(n, op, sgn, a, b, r, x, lat);
        check({tag, ".res"}, r, er);
        check({tag, ".x"}, 32'(x), 32'(ex));
        check({tag, ".lat"}, lat, el);
    endtask

    initial begin
        logic seen;
        int   lat;

        {if32.in_valid, if32.out_ready, if32.signed_op} = '0;
        {if4.in_valid, if4.out_ready, if4.signed_op}    = '0;
        if32.op = '0; if32.a = '0; if32.b = '0;
        if4.op  = '0; if4.a  = '0; if4.b  = '0;

        repeat (3) @(negedge clk);
        check("rst.in_ready", 32'(if32.in_ready), 32'd1);
        check("rst.out_valid", 32'(if32.out_valid), 32'd0);
        check("rst.result", if32.result, 32'd0);
        check("rst.out_x", 32'(if32.out_x), 32'd0);
        check("rst4.result", 32'(if4.result), 32'd0);
        rst = 1'b0;

        // WIDTH=32 multicycle: fixed latency of WIDTH+1
        run("div_s",    0, OP_DIV, 1, 32'd10, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 0, 33);
        run("mod_u",    0, OP_MOD, 0, 32'd10, 32'd3,         32'd1,         0, 33);
        run("mod_sneg", 0, OP_MOD, 1, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 0, 33);
        run("div_min",  0, OP_DIV, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 33);
        run("pow_sneg", 0, OP_POW, 1, 32'hFFFF_FFFE, 32'd3,  32'hFFFF_FFF8, 0, 33);
        run("pow_u",    0, OP_POW, 0, 32'd2, 32'd3,          32'd8,         0, 33);
        run("pow_zneg", 0, OP_POW, 1, 32'd0, 32'hFFFF_FFFF,  32'd0,         1, 33);
        run("pow_m1",   0, OP_POW, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 33);
        run("le_s",     0, OP_LE,  1, 32'hFFFF_FFF6, 32'd10, 32'd1, 0, 1);
        run("le_u",     0, OP_LE,  0, 32'hFFFF_FFF6, 32'd10, 32'd0, 0, 1);
        run("mul",      0, OP_MUL, 0, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 0, 1);

        // WIDTH=4 shifts, reductions and boundary cases
        run("shl4",   1, OP_SHL,   0, 32'b1001, 32'd1, 32'b0010, 0, 1);
        run("ashr4",  1, OP_ASHR,  1, 32'b1110, 32'd1, 32'b1111, 0, 1);
        run("shr4b",  1, OP_SHR,   0, 32'b1111, 32'd4, 32'b0000, 0, 1);
        run("ashr4b", 1, OP_ASHR,  1, 32'b1000, 32'd7, 32'b1111, 0, 1);
        run("ashr4u", 1, OP_ASHR,  0, 32'b1000, 32'd1, 32'b0100, 0, 1);
        run("rand4",  1, OP_RAND,  0, 32'b1001, 32'd0, 32'd0,    0, 1);
        run("rxnor4", 1, OP_RXNOR, 0, 32'b1001, 32'd0, 32'd1,    0, 1);
        run("sub4",   1, OP_SUB,   0, 32'd3,    32'd5, 32'b1110, 0, 1);
        run("div4",   1, OP_DIV,   1, 32'b1001, 32'd2, 32'b1101, 0, 5);
        run("undef4", 1, 5'd31,    0, 32'd3,    32'd3, 32'd0,    1, 1);

        // DIV by zero, then stall the result for five cycles with a competing request
        @(negedge clk);
        if32.in_valid = 1'b1; if32.op = OP_DIV; if32.signed_op = 1'b0; if32.a = 32'd7; if32.b = 32'd0;
        @(posedge clk);
        #1 if32.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!if32.out_valid && lat < 100);
        check("div0.lat", lat, 33);
        check("div0.x", 32'(if32.out_x), 32'd1);
        if32.in_valid = 1'b1; if32.op = OP_ADD; if32.a = 32'd1; if32.b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall.out_valid", 32'(if32.out_valid), 32'd1);
            check("stall.result", if32.result, 32'd0);
            check("stall.out_x", 32'(if32.out_x), 32'd1);
            check("stall.in_ready", 32'(if32.in_ready), 32'd0);
        end
        if32.in_valid  = 1'b0;
        if32.out_ready = 1'b1;
        @(posedge clk);
        #1 if32.out_ready = 1'b0;
        @(negedge clk);
        check("stall.dropped", 32'(if32.out_valid), 32'd0);
        check("stall.idle", 32'(if32.in_ready), 32'd1);

        // Abort a DIV mid-iteration with an asynchronous reset
        @(negedge clk);
        if32.in_valid = 1'b1; if32.op = OP_DIV; if32.a = 32'd100; if32.b = 32'd7;
        @(posedge clk);
        #1 if32.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.out_valid", 32'(if32.out_valid), 32'd0);
        check("abort.in_ready", 32'(if32.in_ready), 32'd1);
        check("abort.result", if32.result, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen |= if32.out_valid;
        end
        check("abort.no_output", 32'(seen), 32'd0);
        run("add_after", 0, OP_ADD, 0, 32'd5, 32'd10, 32'd15, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
